// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter for the consecutive-ones detector, also producing the
// expected detector hit count. Define SEQ_TX_LSB_FIRST_EN to shift frames LSB first.
module seq_pattern_tx #(
  parameter int WIDTH      = 8,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [WIDTH-1:0]           data,
  output logic                       ready,
  output logic                       w,
  output logic                       w_valid,
  output logic                       done,
  output logic [$clog2(WIDTH+1)-1:0] exp_hits
);

  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic [CW-1:0]    exp_hits_q, exp_hits_d;
  logic             prev_q, prev_d;
  logic             ready_q, ready_d;
  logic             w_q, w_d;
  logic             w_valid_q, w_valid_d;
  logic             done_q, done_d;

  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] load_shifted;
  logic [WIDTH-1:0] shreg_shifted;

  // The accepting edge already drives bit 0, so the register holds the remainder.
`ifdef SEQ_TX_LSB_FIRST_EN
  assign first_bit     = data[0];
  assign next_bit      = shreg_q[0];
  assign load_shifted  = {1'b0, data[WIDTH-1:1]};
  assign shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
`else
  assign first_bit     = data[WIDTH-1];
  assign next_bit      = shreg_q[WIDTH-1];
  assign load_shifted  = {data[WIDTH-2:0], 1'b0};
  assign shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
`endif

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    exp_hits_d = exp_hits_q;
    prev_d     = prev_q;
    ready_d    = ready_q;
    w_d        = w_q;
    w_valid_d  = w_valid_q;
    done_d     = done_q;

    case (state_q)
      S_IDLE: begin
        ready_d   = 1'b1;
        w_d       = IDLE_LEVEL;
        w_valid_d = 1'b0;
        done_d    = 1'b0;
        if (start) begin
          state_d    = S_SHIFT;
          shreg_d    = load_shifted;
          bitcnt_d   = '0;
          w_d        = first_bit;
          w_valid_d  = 1'b1;
          prev_d     = first_bit;
          ready_d    = 1'b0;
          // The idle level acts as the bit preceding the frame.
          exp_hits_d = CW'(first_bit & IDLE_LEVEL);
        end
      end

      S_SHIFT: begin
        if (bitcnt_q == CW'(WIDTH - 1)) begin
          state_d   = S_DONE;
          w_d       = IDLE_LEVEL;
          w_valid_d = 1'b0;
          done_d    = 1'b1;
          ready_d   = 1'b0;
        end else begin
          shreg_d   = shreg_shifted;
          bitcnt_d  = bitcnt_q + CW'(1);
          w_d       = next_bit;
          w_valid_d = 1'b1;
          prev_d    = next_bit;
          if (next_bit && prev_q) begin
            exp_hits_d = exp_hits_q + CW'(1);
          end
        end
      end

      S_DONE: begin
        state_d   = S_IDLE;
        ready_d   = 1'b1;
        done_d    = 1'b0;
        w_d       = IDLE_LEVEL;
        w_valid_d = 1'b0;
      end

      default: begin
        state_d   = S_IDLE;
        ready_d   = 1'b1;
        done_d    = 1'b0;
        w_d       = IDLE_LEVEL;
        w_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      exp_hits_q <= '0;
      prev_q     <= IDLE_LEVEL;
      ready_q    <= 1'b1;
      w_q        <= IDLE_LEVEL;
      w_valid_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      exp_hits_q <= exp_hits_d;
      prev_q     <= prev_d;
      ready_q    <= ready_d;
      w_q        <= w_d;
      w_valid_q  <= w_valid_d;
      done_q     <= done_d;
    end
  end

  assign ready    = ready_q;
  assign w        = w_q;
  assign w_valid  = w_valid_q;
  assign done     = done_q;
  assign exp_hits = exp_hits_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: positional frame model checked every cycle,
// directed frames with literal expectations, randomized traffic, and a WIDTH=4/IDLE=1 instance.
module tb_seq_pattern_tx;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, w, w_valid, done;
  logic [3:0] exp_hits;

  logic       start4 = 1'b0;
  logic [3:0] data4 = 4'h0;
  logic       ready4, w4, w_valid4, done4;
  logic [2:0] exp_hits4;

  int tests = 0;
  int fails = 0;

  seq_pattern_tx #(.WIDTH(8), .IDLE_LEVEL(1'b0)) dut (
    .clock(clock), .resetn(resetn), .start(start), .data(data),
    .ready(ready), .w(w), .w_valid(w_valid), .done(done), .exp_hits(exp_hits)
  );

  seq_pattern_tx #(.WIDTH(4), .IDLE_LEVEL(1'b1)) dut4 (
    .clock(clock), .resetn(resetn), .start(start4), .data(data4),
    .ready(ready4), .w(w4), .w_valid(w_valid4), .done(done4), .exp_hits(exp_hits4)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model (8-bit, idle level 0) ----------------
  // Position in the frame timeline: -1 idle, 0..7 frame bit on w, 8 done cycle.
  int         m_pos = -1;
  logic [7:0] m_word = 8'h00;
  int         m_hold = 0;

  function automatic logic mbit(input logic [7:0] word, input int k);
`ifdef SEQ_TX_LSB_FIRST_EN
    return word[k];
`else
    return word[7-k];
`endif
  endfunction

  // Number of 1 bits among transmitted bits 0..upto whose predecessor was also 1.
  function automatic int model_hits(input logic [7:0] word, input int upto);
    int   h = 0;
    logic p = 1'b0;
    for (int k = 0; k <= upto; k++) begin
      if (mbit(word, k) && p) h++;
      p = mbit(word, k);
    end
    return h;
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_pos  = -1;
      m_word = 8'h00;
      m_hold = 0;
    end else if (m_pos < 0) begin
      if (start) begin
        m_word = data;
        m_pos  = 0;
      end
    end else if (m_pos < 8) begin
      m_pos = m_pos + 1;
    end else begin
      m_hold = model_hits(m_word, 7);
      m_pos  = -1;
    end
  end

  // ---------------- checking helpers ----------------
  logic [7:0] rx = 8'h00;
  int         done_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle_check();
    logic       e_ready, e_w, e_v, e_d;
    logic [3:0] e_h;
    if (m_pos < 0) begin
      e_ready = 1'b1; e_w = 1'b0; e_v = 1'b0; e_d = 1'b0; e_h = 4'(m_hold);
    end else if (m_pos < 8) begin
      e_ready = 1'b0; e_w = mbit(m_word, m_pos); e_v = 1'b1; e_d = 1'b0;
      e_h = 4'(model_hits(m_word, m_pos));
    end else begin
      e_ready = 1'b0; e_w = 1'b0; e_v = 1'b0; e_d = 1'b1; e_h = 4'(model_hits(m_word, 7));
    end
    tests++;
    if (ready !== e_ready || w !== e_w || w_valid !== e_v || done !== e_d || exp_hits !== e_h) begin
      fails++;
      $display("FAIL cycle t=%0t: ready/w/w_valid/done/exp_hits = %b/%b/%b/%b/%0d, expected %b/%b/%b/%b/%0d",
               $time, ready, w, w_valid, done, exp_hits, e_ready, e_w, e_v, e_d, e_h);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    cycle_check();
    if (w_valid) rx = {rx[6:0], w};
    if (done) done_cnt++;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 40);
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL wait_done: done=%b after %0d cycles, expected 1 within 40", done, n);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
    check("wait_ready", int'(ready), 1);
  endtask

  task automatic send(input logic [7:0] word);
    rx = 8'h00;
    done_cnt = 0;
    data = word;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, gap, ngaps;
    bit seen;

    // Reset state
    tick();
    tick();
    check("rst_ready", int'(ready), 1);
    check("rst_w", int'(w), 0);
    check("rst_w_valid", int'(w_valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_exp_hits", int'(exp_hits), 0);
    check("rst4_ready", int'(ready4), 1);
    check("rst4_w_idle_level", int'(w4), 1);
    check("rst4_exp_hits", int'(exp_hits4), 0);
    resetn = 1'b1;
    tick();
    tick();

    // Basic frame 0110_1110
    send(8'b0110_1110);
    wait_done(n);
    check("t2_latency", n, 8);
`ifdef SEQ_TX_LSB_FIRST_EN
    check("t2_rx", int'(rx), 8'h76);
`else
    check("t2_rx", int'(rx), 8'h6E);
`endif
    check("t2_exp_hits", int'(exp_hits), 3);
    $display("[TB] frame data=6e exp_hits=%0d", exp_hits);
    tick();

    // All ones, with a start pulse during SHIFT that must be ignored
    send(8'hFF);
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    check("t3_latency", n, 5);
    check("t3_exp_hits", int'(exp_hits), 7);
    tick(); tick(); tick();
    check("t3_done_pulses", done_cnt, 1);
    check("t3_exp_hits_hold", int'(exp_hits), 7);
    $display("[TB] frame data=ff exp_hits=%0d", exp_hits);

    // start held high: back-to-back frames separated by exactly two idle cycles
    data = 8'hA5;
    start = 1'b1;
    gap = 0; ngaps = 0; seen = 1'b0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (w_valid) begin
        if (seen && gap != 0) begin
          check("t4_gap", gap, 2);
          ngaps++;
        end
        seen = 1'b1;
        gap = 0;
      end else if (seen) begin
        gap++;
      end
      if (done) begin
        check("t4_exp_hits", int'(exp_hits), 0);
        $display("[TB] frame data=a5 exp_hits=%0d", exp_hits);
      end
    end
    check("t4_gap_count", ngaps, 4);
    start = 1'b0;
    wait_ready();

    // Reset during the 4th bit aborts the frame
    send(8'hB7);
    tick(); tick(); tick();
    #2 resetn = 1'b0;
    #1;
    check("t5_ready", int'(ready), 1);
    check("t5_w", int'(w), 0);
    check("t5_w_valid", int'(w_valid), 0);
    check("t5_exp_hits", int'(exp_hits), 0);
    tick();
    tick();
    resetn = 1'b1;
    tick(); tick(); tick();
    check("t5_no_done", done_cnt, 0);
    check("t5_exp_hits_after", int'(exp_hits), 0);
    $display("[TB] frame data=b7 aborted by reset");

    // Bit order boundary word
    send(8'b0000_0011);
    wait_done(n);
`ifdef SEQ_TX_LSB_FIRST_EN
    check("t6_rx", int'(rx), 8'hC0);
`else
    check("t6_rx", int'(rx), 8'h03);
`endif
    check("t6_exp_hits", int'(exp_hits), 1);
    $display("[TB] frame data=03 exp_hits=%0d", exp_hits);
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      int sel;
      sel = $urandom_range(0, 5);
      start = ($urandom_range(0, 2) == 0);
      data = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
      tick();
      if (done) $display("[TB] frame data=%02h exp_hits=%0d", m_word, exp_hits);
    end
    start = 1'b0;
    wait_ready();

    // WIDTH=4, IDLE_LEVEL=1 instance
    foreach (data4[i]) data4[i] = 1'b0;
    data4 = 4'b1000;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 20) begin tick(); n++; end
    check("t7_done4_seen", int'(done4), 1);
    check("t7_latency4", n, 4);
    check("t7_w4_idle", int'(w4), 1);
`ifdef SEQ_TX_LSB_FIRST_EN
    check("t7_exp_hits4_1000", int'(exp_hits4), 0);
`else
    check("t7_exp_hits4_1000", int'(exp_hits4), 1);
`endif
    $display("[TB] frame4 data=8 exp_hits=%0d", exp_hits4);
    tick();
    tick();
    data4 = 4'b1111;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 20) begin tick(); n++; end
    check("t7_done4_seen_b", int'(done4), 1);
    check("t7_exp_hits4_1111", int'(exp_hits4), 4);
    $display("[TB] frame4 data=f exp_hits=%0d", exp_hits4);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
